// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg
// Shared definitions for the bit serializer slice:
//   - WORD_W / IDX_W : data width and bit-index width
//   - state_t        : serializer state (IDLE, SHIFT, PAR)
//   - even_par_step  : one step of the running even-parity accumulator
package bit_serializer_pkg;

  localparam int WORD_W = 32;
  localparam int IDX_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  // Fold one transmitted bit into the even-parity accumulator.
  function automatic logic even_par_step(input logic acc, input logic data_bit);
    return acc ^ data_bit;
  endfunction

endpackage

// File: rtl/bit_select32.sv
// bit_select32
// Purely combinational 32:1 bit selector built as a five-level tree of
// 2:1 selects (sel[0] picks at the leaves, sel[4] at the root).
// Ports:
//   word    in  32  source word
//   sel     in  5   bit index to pick
//   sel_bit out 1   word[sel]
module bit_select32
  import bit_serializer_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [IDX_W-1:0]  sel,
  output logic              sel_bit
);

  logic [15:0] lvl1;
  logic [7:0]  lvl2;
  logic [3:0]  lvl3;
  logic [1:0]  lvl4;

  // Reduce the word pairwise, one select bit per tree level.
  always_comb begin
    lvl1 = 16'd0;
    lvl2 = 8'd0;
    lvl3 = 4'd0;
    lvl4 = 2'd0;
    for (int i = 0; i < 16; i++) lvl1[i] = sel[0] ? word[2*i+1] : word[2*i];
    for (int i = 0; i < 8; i++)  lvl2[i] = sel[1] ? lvl1[2*i+1] : lvl1[2*i];
    for (int i = 0; i < 4; i++)  lvl3[i] = sel[2] ? lvl2[2*i+1] : lvl2[2*i];
    for (int i = 0; i < 2; i++)  lvl4[i] = sel[3] ? lvl3[2*i+1] : lvl3[2*i];
    sel_bit = sel[4] ? lvl4[1] : lvl4[0];
  end

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer
// Parallel-to-serial converter: accepts a 32-bit word with a length over a
// valid/ready handshake and emits bits LSB first, one per beat, over a second
// valid/ready handshake. Optional trailing even-parity beat when the macro
// PARITY_EN is defined (default build: no parity beat, no parity register).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input handshake; in_data (32), in_len (5, bits-1)
//   out_valid/out_ready output handshake; out_bit, out_last, out_idx (5)
//   busy                a word is held (state is not IDLE)
module bit_serializer
  import bit_serializer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last,
  output logic [IDX_W-1:0]  out_idx,
  output logic              busy
);

  state_t            state;
  logic [WORD_W-1:0] word;
  logic [IDX_W-1:0]  len;
  logic [IDX_W-1:0]  idx;
`ifdef PARITY_EN
  logic              par;
`endif

  logic data_bit;
  logic at_end;
  logic beat_fire;
  logic final_fire;
  logic accept;

  bit_select32 u_bit_select32 (
    .word    (word),
    .sel     (idx),
    .sel_bit (data_bit)
  );

  // Output decode: driven from registers only, zero whenever idle.
  always_comb begin
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    out_idx   = {IDX_W{1'b0}};
    case (state)
      SHIFT: begin
        out_valid = 1'b1;
        out_bit   = data_bit;
        out_idx   = idx;
`ifdef PARITY_EN
        out_last  = 1'b0;
`else
        out_last  = at_end;
`endif
      end
      PAR: begin
`ifdef PARITY_EN
        out_valid = 1'b1;
        out_bit   = par;
        out_last  = 1'b1;
`else
        out_valid = 1'b0;
`endif
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  assign at_end     = (idx == len);
  assign busy       = (state != IDLE);
  assign beat_fire  = out_valid && out_ready;
  assign final_fire = beat_fire && out_last;
  // Accepting on the final fire lets the next word start with no bubble.
  assign in_ready   = rst_n && ((state == IDLE) || final_fire);
  assign accept     = in_valid && in_ready;

  // State, word, length, bit counter and parity accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      word  <= {WORD_W{1'b0}};
      len   <= {IDX_W{1'b0}};
      idx   <= {IDX_W{1'b0}};
`ifdef PARITY_EN
      par   <= 1'b0;
`endif
    end else if (accept) begin
      // Accept only happens when idle or on the final fire, so it overrides.
      word  <= in_data;
      len   <= in_len;
      idx   <= {IDX_W{1'b0}};
`ifdef PARITY_EN
      par   <= 1'b0;
`endif
      state <= SHIFT;
    end else if (beat_fire) begin
      case (state)
        SHIFT: begin
`ifdef PARITY_EN
          par <= even_par_step(par, data_bit);
`endif
          if (at_end) begin
`ifdef PARITY_EN
            state <= PAR;
`else
            state <= IDLE;
`endif
          end else begin
            // Never wraps: the last beat stops at idx==len.
            idx <= idx + 5'd1;
          end
        end
        PAR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end else begin
      state <= state;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic [4:0]  in_len = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_bit;
  logic        out_last;
  logic [4:0]  out_idx;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

  // Expected beat stream from the model, and observed beat stream.
  logic [32:0]  exp_bits, got_bits;
  logic [164:0] exp_idxs, got_idxs;
  int           exp_n, got_n, got_last_pos;
  bit           timed_out;
  logic         stall_bit_q[$];
  logic [4:0]   stall_idx_q[$];
  logic         stall_last_q[$];
  logic         stall_valid_q[$];

  bit_serializer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .out_valid(out_valid),
    .out_ready(out_ready), .out_bit(out_bit), .out_last(out_last),
    .out_idx(out_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: len+1 data bits LSB first, then optional even-parity beat.
  task automatic model_word(input logic [31:0] d, input logic [4:0] l);
    logic [32:0] m;
    exp_bits = '0;
    exp_idxs = '0;
    exp_n = 0;
    for (int i = 0; i <= int'(l); i++) begin
      exp_bits[exp_n] = d[i];
      exp_idxs[exp_n*5 +: 5] = 5'(i);
      exp_n++;
    end
`ifdef PARITY_EN
    m = (33'd1 << (int'(l) + 1)) - 33'd1;
    exp_bits[exp_n] = ^(d & m[31:0]);
    exp_idxs[exp_n*5 +: 5] = 5'd0;
    exp_n++;
`endif
  endtask

  // Offer one word, then collect fired beats until out_last fires.
  task automatic collect_word(input logic [31:0] d, input logic [4:0] l,
                              input bit rnd, input int stall_at, input int stall_len);
    int cyc;
    bit done, stalled;
    got_bits = '0; got_idxs = '0; got_n = 0; got_last_pos = -1; timed_out = 0;
    stall_bit_q.delete(); stall_idx_q.delete(); stall_last_q.delete(); stall_valid_q.delete();
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_len = l; out_ready = 1'b1;
    #1;
    cyc = 0;
    while (!in_ready && cyc < 50) begin @(negedge clk); #1; cyc++; end
    if (!in_ready) timed_out = 1;
    @(posedge clk);
    done = 0; stalled = 0; cyc = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data = $urandom;
      in_len = 5'($urandom_range(0, 31));
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_at >= 0 && !stalled && out_valid && int'(out_idx) == stall_at) begin
        stalled = 1;
        for (int k = 0; k < stall_len; k++) begin
          out_ready = 1'b0;
          #1;
          stall_bit_q.push_back(out_bit);
          stall_idx_q.push_back(out_idx);
          stall_last_q.push_back(out_last);
          stall_valid_q.push_back(out_valid);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && out_ready && got_n < 33) begin
        got_bits[got_n] = out_bit;
        got_idxs[got_n*5 +: 5] = out_idx;
        if (out_last) begin got_last_pos = got_n; done = 1; end
        got_n++;
      end
      cyc++;
    end
    if (!done) timed_out = 1;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %0b expected 0", out_last); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (out_bit !== 1'b0) begin n_fail++; $display("FAIL reset_out_bit: got %0b expected 0", out_bit); end
    n_checks++; if (out_idx !== 5'd0) begin n_fail++; $display("FAIL reset_out_idx: got %0d expected 0", out_idx); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %0b expected 0", in_ready); end
    rst_n = 1'b1; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_release: got %0b expected 1", in_ready); end
  endtask

  task automatic test_word(input string name, input logic [31:0] d, input logic [4:0] l,
                           input bit rnd);
    model_word(d, l);
    collect_word(d, l, rnd, -1, 0);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: got %0b expected 0", name, timed_out); end
    n_checks++; if (got_n !== exp_n) begin n_fail++; $display("FAIL %s_beats: got %0d expected %0d", name, got_n, exp_n); end
    n_checks++; if (got_bits !== exp_bits) begin n_fail++; $display("FAIL %s_bits: got %h expected %h", name, got_bits, exp_bits); end
    n_checks++; if (got_idxs !== exp_idxs) begin n_fail++; $display("FAIL %s_idx: got %h expected %h", name, got_idxs, exp_idxs); end
    n_checks++; if (got_last_pos !== exp_n - 1) begin n_fail++; $display("FAIL %s_last_pos: got %0d expected %0d", name, got_last_pos, exp_n - 1); end
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_after: got %0b expected 0", name, busy); end
  endtask

  task automatic test_backpressure;
    model_word(32'hA5A5_A5A5, 5'd31);
    collect_word(32'hA5A5_A5A5, 5'd31, 1'b0, 5, 3);
    n_checks++; if (stall_bit_q.size() !== 3) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d expected 3", stall_bit_q.size()); end
    foreach (stall_bit_q[k]) begin
      n_checks++; if (stall_valid_q[k] !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %0b expected 1", k, stall_valid_q[k]); end
      n_checks++; if (stall_bit_q[k] !== 1'b1) begin n_fail++; $display("FAIL bp_bit[%0d]: got %0b expected 1", k, stall_bit_q[k]); end
      n_checks++; if (stall_idx_q[k] !== 5'd5) begin n_fail++; $display("FAIL bp_idx[%0d]: got %0d expected 5", k, stall_idx_q[k]); end
      n_checks++; if (stall_last_q[k] !== 1'b0) begin n_fail++; $display("FAIL bp_last[%0d]: got %0b expected 0", k, stall_last_q[k]); end
    end
    n_checks++; if (got_n !== exp_n) begin n_fail++; $display("FAIL bp_beats: got %0d expected %0d", got_n, exp_n); end
    n_checks++; if (got_bits !== exp_bits) begin n_fail++; $display("FAIL bp_bits: got %h expected %h", got_bits, exp_bits); end
    n_checks++; if (got_idxs !== exp_idxs) begin n_fail++; $display("FAIL bp_idx: got %h expected %h", got_idxs, exp_idxs); end
  endtask

  task automatic test_back_to_back;
    int cyc, cnt;
    logic rdy_on_last;
    rdy_on_last = 1'b0;
    model_word(32'hFFFF_FFFF, 5'd3);
    got_bits = '0; got_idxs = '0; got_n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_len = 5'd3; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_data = 32'h0000_0000;
    cyc = 0;
    while (cyc < 100) begin
      #1;
      if (out_valid && got_n < 33) begin
        got_bits[got_n] = out_bit;
        got_idxs[got_n*5 +: 5] = out_idx;
        got_n++;
        if (out_last) begin rdy_on_last = in_ready; break; end
      end
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++; if (rdy_on_last !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_on_last: got %0b expected 1", rdy_on_last); end
    n_checks++; if (got_bits !== exp_bits) begin n_fail++; $display("FAIL b2b_w1_bits: got %h expected %h", got_bits, exp_bits); end
    n_checks++; if (got_n !== exp_n) begin n_fail++; $display("FAIL b2b_w1_beats: got %0d expected %0d", got_n, exp_n); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_w2_valid: got %0b expected 1", out_valid); end
    n_checks++; if (out_idx !== 5'd0) begin n_fail++; $display("FAIL b2b_w2_idx: got %0d expected 0", out_idx); end
    n_checks++; if (out_bit !== 1'b0) begin n_fail++; $display("FAIL b2b_w2_bit: got %0b expected 0", out_bit); end
    model_word(32'h0000_0000, 5'd3);
    cnt = 1; cyc = 0;
    while (!(out_valid && out_last) && cyc < 100) begin
      @(negedge clk); #1;
      if (out_valid) cnt++;
      cyc++;
    end
    @(negedge clk); #1;
    n_checks++; if (cnt !== exp_n) begin n_fail++; $display("FAIL b2b_w2_beats: got %0d expected %0d", cnt, exp_n); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after: got %0b expected 0", busy); end
  endtask

  task automatic test_mid_reset;
    int cyc;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_len = 5'd31; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    cyc = 0;
    while (!(out_valid && out_idx == 5'd10) && cyc < 100) begin @(negedge clk); #1; cyc++; end
    n_checks++; if (out_idx !== 5'd10) begin n_fail++; $display("FAIL mid_reach_idx10: got %0d expected 10", out_idx); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready_low: got %0b expected 0", in_ready); end
    rst_n = 1'b1; #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %0b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %0b expected 0", busy); end
    n_checks++; if (out_idx !== 5'd0) begin n_fail++; $display("FAIL mid_out_idx: got %0d expected 0", out_idx); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL mid_out_last: got %0b expected 0", out_last); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %0b expected 1", in_ready); end
  endtask

  task automatic test_random;
    logic [31:0] d;
    logic [4:0]  l;
    for (int t = 0; t < 20; t++) begin
      d = $urandom;
      l = 5'($urandom_range(0, 31));
      test_word("random", d, l, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_word("full_word", 32'h8000_0001, 5'd31, 1'b0);
    test_word("short_word", 32'h0000_0006, 5'd2, 1'b0);
    test_word("odd_parity", 32'h0000_0007, 5'd2, 1'b0);
    test_word("len_zero", 32'h0000_0001, 5'd0, 1'b0);
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
